mips_multicycle_ctrl: RTL

- Multicycle MIPS control unit: the initiator side of the datapath ALU.
- Sequences each instruction through fetch, decode, execute, memory and write-back states.
- Drives ALU operand selects and the 3-bit ALU op code, and consumes the ALU Zero flag for branches.
- Sits between the instruction register (opcode/funct) and the datapath muxes, register file and memory enables.

---
 rtl/mips_multicycle_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM that sequences fetch, decode,
// execute, memory and write-back, and drives the datapath selects/enables.
module mips_multicycle_ctrl #(
  parameter int unsigned OP_WIDTH    = 3,
  parameter int unsigned STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   zero,
  output logic                   pc_en,
  output logic                   iord,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_src,
  output logic [OP_WIDTH-1:0]    alu_op,
  output logic                   illegal,
  output logic [STATE_WIDTH-1:0] state
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecute = 4'd6,
    StAluWb   = 4'd7,
    StBranch  = 4'd8,
    StAddiEx  = 4'd9,
    StAddiWb  = 4'd10,
    StJump    = 4'd11
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpJ     = 6'b000010;

  localparam logic [2:0] AluAnd = 3'd0;
  localparam logic [2:0] AluOr  = 3'd1;
  localparam logic [2:0] AluAdd = 3'd2;
  localparam logic [2:0] AluSub = 3'd6;
  localparam logic [2:0] AluSlt = 3'd7;

  state_e     state_q, state_d;
  logic       pc_write, branch;
  logic       funct_ok;
  logic [2:0] funct_op, op_code;

  // State register with synchronous reset back to fetch.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // R-type funct decode; funct_ok low marks an unsupported funct.
  always_comb begin
    funct_ok = 1'b1;
    funct_op = AluAdd;
    case (funct)
      6'b100100: funct_op = AluAnd;
      6'b100101: funct_op = AluOr;
      6'b100000: funct_op = AluAdd;
      6'b100010: funct_op = AluSub;
      6'b101010: funct_op = AluSlt;
      default:   funct_ok = 1'b0;
    endcase
  end

  // Next-state and per-state output decode, with reset gating of all enables.
  always_comb begin
    state_d    = StFetch;
    pc_write   = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    op_code    = AluAdd;
    illegal    = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write  = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
        state_d   = StDecode;
      end
      StDecode: begin
        alu_src_b = 2'b11;  // branch target precompute
        case (opcode)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExecute;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
          default: begin
            state_d = StFetch;
            illegal = 1'b1;
          end
        endcase
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OpLw) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        iord    = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StExecute: begin
        alu_src_a = 1'b1;
        op_code   = funct_op;
        illegal   = ~funct_ok;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_dst   = 1'b1;
        reg_write = funct_ok;  // IR is stable, so funct still identifies a bad op
      end
      StBranch: begin
        alu_src_a = 1'b1;
        op_code   = AluSub;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StAddiWb;
      end
      StAddiWb: begin
        reg_write = 1'b1;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: state_d = StFetch;
    endcase
    // Abandon any in-flight instruction: no writes while reset is high.
    if (reset) begin
      pc_write  = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign pc_en  = pc_write | (branch & zero);
  assign alu_op = OP_WIDTH'(op_code);
  assign state  = STATE_WIDTH'(state_q);

endmodule
